// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the FSM state encoding, port indices, the memory-size default and small helper functions.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int PORT0             = 0;
  localparam int PORT1             = 1;
  localparam int MEM_BYTES_DEFAULT = 1024;

  function automatic int cnt_width(input int max_run);
    return (max_run < 1) ? 1 : $clog2(max_run + 1);
  endfunction

  // Misaligned or past the last full word of the memory.
  function automatic logic addr_err(input logic [31:0] addr, input int mem_bytes);
    return (addr[1:0] != 2'b00) || (addr > 32'(mem_bytes - 4));
  endfunction

endpackage

// File: rtl/arb_fair_sel.sv
// Fair two-way selector: port 0 wins ties until it has won MAX_P0_RUN times in a row over a waiting port 1.
// Purely combinational; produces a one-hot grant and the run-counter value to store if the grant is taken.
module arb_fair_sel
  import mem_arb_pkg::*;
#(
  parameter int MAX_P0_RUN = 2,
  parameter int CNT_W      = 2
) (
  input  logic             v0,
  input  logic             v1,
  input  logic [CNT_W-1:0] run_cnt,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] run_cnt_nxt
);

  logic run_full;
  logic p1_turn;

  assign run_full = (run_cnt == CNT_W'(MAX_P0_RUN));
  assign p1_turn  = v1 && (!v0 || run_full);

  always_comb begin
    grant       = 2'b00;
    run_cnt_nxt = run_cnt;
    if (p1_turn) begin
      grant[PORT1] = 1'b1;
      run_cnt_nxt  = '0;
    end else if (v0) begin
      grant[PORT0] = 1'b1;
      // Only a starved port 1 makes a port-0 win count toward the run limit.
      if (!v1) begin
        run_cnt_nxt = '0;
      end else if (!run_full) begin
        run_cnt_nxt = run_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory; one transaction in flight (IDLE->ACCESS->RESP).
// Accept at T gives rvalid at T+2 (T+1 for address errors); ready only in IDLE for the winner, requesters hold until ready.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_P0_RUN = 2,
  parameter int MEM_BYTES  = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_valid,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ready,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_valid,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ready,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = cnt_width(MAX_P0_RUN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d, run_cnt_upd;
  logic             we_q, we_d;
  logic             port_q, port_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [1:0]       rvalid_q, rvalid_d;

  logic [1:0]       grant;
  logic             accept;
  logic             sel_port;
  logic             sel_we;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic             sel_err;

  arb_fair_sel #(
    .MAX_P0_RUN (MAX_P0_RUN),
    .CNT_W      (CNT_W)
  ) u_sel (
    .v0          (p0_valid),
    .v1          (p1_valid),
    .run_cnt     (run_cnt_q),
    .grant       (grant),
    .run_cnt_nxt (run_cnt_upd)
  );

  assign accept    = (state_q == ST_IDLE) && (p0_valid || p1_valid);
  assign sel_port  = grant[PORT1];
  assign sel_we    = sel_port ? p1_we    : p0_we;
  assign sel_addr  = sel_port ? p1_addr  : p0_addr;
  assign sel_wdata = sel_port ? p1_wdata : p0_wdata;
  assign sel_err   = addr_err(sel_addr, MEM_BYTES);

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    we_d        = we_q;
    port_d      = port_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    rvalid_d    = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          run_cnt_d = run_cnt_upd;
          we_d      = sel_we;
          port_d    = sel_port;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          rdata_d   = '0;
          err_d     = sel_err;
          if (sel_err) begin
            // Bad address: answer straight away without touching memory.
            state_d            = ST_RESP;
            rvalid_d[sel_port] = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            mem_read_d  = !sel_we;
            mem_write_d = sel_we;
          end
        end
      end
      ST_ACCESS: begin
        state_d          = ST_RESP;
        rdata_d          = we_q ? 32'd0 : mem_rdata;
        rvalid_d[port_q] = 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      run_cnt_q   <= '0;
      we_q        <= 1'b0;
      port_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rvalid_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      we_q        <= we_d;
      port_q      <= port_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // Ready is gated by rst_n so it is also low while reset is held.
  assign p0_ready  = rst_n && accept && grant[PORT0];
  assign p1_ready  = rst_n && accept && grant[PORT1];

  assign p0_rvalid = rvalid_q[PORT0];
  assign p1_rvalid = rvalid_q[PORT1];
  assign p0_rdata  = rvalid_q[PORT0] ? rdata_q : 32'd0;
  assign p1_rdata  = rvalid_q[PORT1] ? rdata_q : 32'd0;
  assign p0_err    = rvalid_q[PORT0] && err_q;
  assign p1_err    = rvalid_q[PORT1] && err_q;

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small word-addressed memory model on the mem_* side.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_valid, p0_we, p0_ready, p0_rvalid, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_valid, p1_we, p1_ready, p1_rvalid, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  int          compared   = 0;
  int          mismatched = 0;
  int          rd_seen    = 0;
  int          both_seen  = 0;

  mem_arbiter #(.MAX_P0_RUN(2), .MEM_BYTES(1024)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_valid  (p0_valid),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_ready  (p0_ready),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p0_err    (p0_err),
    .p1_valid  (p1_valid),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_ready  (p1_ready),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .p1_err    (p1_err),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  always @(negedge clk) begin
    if (mem_read) rd_seen++;
    if (mem_read && mem_write) both_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       got [0:5];
    logic       exp_order [0:5];
    int         n;
    int         last_c;
    int         rd_snap;
    int         rv_seen;

    exp_order[0] = 1'b0; exp_order[1] = 1'b0; exp_order[2] = 1'b1;
    exp_order[3] = 1'b0; exp_order[4] = 1'b0; exp_order[5] = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[0]   = 32'h0000_0004;
    mem[255] = 32'hA5A5_0FF0;

    rst_n = 1'b0;
    p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;

    // Reset state, including ready held low with a request present.
    #2;
    chk("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);
    p0_valid = 1'b1;
    #1;
    chk("rst_p0_ready", {31'd0, p0_ready}, 32'd0);
    p0_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // p0 read of address 0.
    @(negedge clk);
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h0;
    #1;
    chk("t1_p0_ready", {31'd0, p0_ready}, 32'd1);
    chk("t1_p1_ready", {31'd0, p1_ready}, 32'd0);
    chk("t1_idle_mem_read", {31'd0, mem_read}, 32'd0);
    @(negedge clk);
    p0_valid = 1'b0;
    chk("t1_mem_read", {31'd0, mem_read}, 32'd1);
    chk("t1_mem_write", {31'd0, mem_write}, 32'd0);
    chk("t1_mem_addr", mem_addr, 32'h0);
    chk("t1_rvalid_early", {31'd0, p0_rvalid}, 32'd0);
    @(negedge clk);
    chk("t1_p0_rvalid", {31'd0, p0_rvalid}, 32'd1);
    chk("t1_p0_rdata", p0_rdata, 32'h0000_0004);
    chk("t1_p0_err", {31'd0, p0_err}, 32'd0);
    chk("t1_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    chk("t1_resp_mem_read", {31'd0, mem_read}, 32'd0);
    @(negedge clk);
    chk("t1_rvalid_pulse", {31'd0, p0_rvalid}, 32'd0);

    // p1 write 0x10, then p0 reads it back.
    p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 32'h10; p1_wdata = 32'hDEAD_BEEF;
    #1;
    chk("t2_p1_ready", {31'd0, p1_ready}, 32'd1);
    chk("t2_p0_ready", {31'd0, p0_ready}, 32'd0);
    @(negedge clk);
    p1_valid = 1'b0;
    chk("t2_mem_write", {31'd0, mem_write}, 32'd1);
    chk("t2_mem_read", {31'd0, mem_read}, 32'd0);
    chk("t2_mem_addr", mem_addr, 32'h10);
    chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t2_p1_rvalid", {31'd0, p1_rvalid}, 32'd1);
    chk("t2_p1_rdata", p1_rdata, 32'd0);
    chk("t2_p1_err", {31'd0, p1_err}, 32'd0);
    chk("t2_hold_addr", mem_addr, 32'h10);
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    #1;
    chk("t2_resp_no_ready", {31'd0, p0_ready}, 32'd0);
    @(negedge clk);
    chk("t2_p0_ready", {31'd0, p0_ready}, 32'd1);
    @(negedge clk);
    p0_valid = 1'b0;
    @(negedge clk);
    chk("t2_p0_rvalid", {31'd0, p0_rvalid}, 32'd1);
    chk("t2_p0_rdata", p0_rdata, 32'hDEAD_BEEF);

    // Both ports requesting continuously: fairness order and 3-cycle spacing.
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h0;
    p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h10;
    n = 0;
    last_c = -1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk);
      #1;
      if (p0_ready || p1_ready) begin
        got[n] = p1_ready;
        n++;
        last_c = c;
      end
    end
    chk("t3_grant_count", n, 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < n) chk($sformatf("t3_grant%0d", i), {31'd0, got[i]}, {31'd0, exp_order[i]});
    end
    chk("t3_last_grant_cycle", last_c, 32'd15);
    @(negedge clk);
    p0_valid = 1'b0; p1_valid = 1'b0;
    @(negedge clk);
    chk("t3_p1_rvalid", {31'd0, p1_rvalid}, 32'd1);
    chk("t3_p1_rdata", p1_rdata, 32'hDEAD_BEEF);
    @(negedge clk);

    // Address errors: misaligned and one word past the end.
    rd_snap = rd_seen;
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h6;
    #1;
    chk("t4a_ready", {31'd0, p0_ready}, 32'd1);
    @(negedge clk);
    p0_valid = 1'b0;
    chk("t4a_rvalid", {31'd0, p0_rvalid}, 32'd1);
    chk("t4a_err", {31'd0, p0_err}, 32'd1);
    chk("t4a_rdata", p0_rdata, 32'd0);
    @(negedge clk);
    p0_valid = 1'b1; p0_addr = 32'h400;
    #1;
    chk("t4b_ready", {31'd0, p0_ready}, 32'd1);
    @(negedge clk);
    p0_valid = 1'b0;
    chk("t4b_rvalid", {31'd0, p0_rvalid}, 32'd1);
    chk("t4b_err", {31'd0, p0_err}, 32'd1);
    chk("t4b_rdata", p0_rdata, 32'd0);
    chk("t4b_mem_addr", mem_addr, 32'h400);
    chk("t4_no_mem_read", rd_seen - rd_snap, 32'd0);
    @(negedge clk);
    p0_valid = 1'b1; p0_addr = 32'h3FC;
    #1;
    chk("t4c_ready", {31'd0, p0_ready}, 32'd1);
    @(negedge clk);
    p0_valid = 1'b0;
    @(negedge clk);
    chk("t4c_rvalid", {31'd0, p0_rvalid}, 32'd1);
    chk("t4c_err", {31'd0, p0_err}, 32'd0);
    chk("t4c_rdata", p0_rdata, 32'hA5A5_0FF0);
    @(negedge clk);

    // Reset asserted while ACCESS is driving the memory.
    p0_valid = 1'b1; p0_addr = 32'h0;
    @(negedge clk);
    p0_valid = 1'b0;
    chk("t5_mem_read_pre", {31'd0, mem_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_mem_read_async", {31'd0, mem_read}, 32'd0);
    chk("t5_mem_addr_rst", mem_addr, 32'd0);
    rv_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (p0_rvalid || p1_rvalid) rv_seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (p0_rvalid || p1_rvalid) rv_seen++;
    end
    chk("t5_no_rvalid", rv_seen, 32'd0);
    p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h10;
    #1;
    chk("t5_p1_ready", {31'd0, p1_ready}, 32'd1);
    @(negedge clk);
    p1_valid = 1'b0;
    @(negedge clk);
    chk("t5_p1_rvalid", {31'd0, p1_rvalid}, 32'd1);
    chk("t5_p1_rdata", p1_rdata, 32'hDEAD_BEEF);
    @(negedge clk);

    chk("never_read_and_write", both_seen, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_P0_RUN, default 2: maximum consecutive port-0 grants while port 1 waits.
REQ-002 Parameter MEM_BYTES, default 1024: data memory size in bytes.
REQ-003 clk  in  1  single clock, all state rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 pN_valid  in  1  port N request (N=0 pipeline MEM stage, N=1 loader/debug).
REQ-006 pN_we  in  1  port N write (1) / read (0).
REQ-007 pN_addr  in  32  port N byte address.
REQ-008 pN_wdata  in  32  port N write data.
REQ-009 pN_ready  out  1  port N request accepted this cycle.
REQ-010 pN_rvalid  out  1  port N response pulse.
REQ-011 pN_rdata  out  32  port N read data, valid with pN_rvalid.
REQ-012 pN_err  out  1  port N error flag, valid with pN_rvalid.
REQ-013 mem_read  out  1  to memory memRead.
REQ-014 mem_write  out  1  to memory memWrite.
REQ-015 mem_addr  out  32  to memory address.
REQ-016 mem_wdata  out  32  to memory writeMData.
REQ-017 mem_rdata  in  32  from memory readMData (combinational).

Function
REQ-018 FSM states: IDLE, ACCESS, RESP; exactly one transaction in flight.
REQ-019 IDLE: if any pN_valid, select winner, assert winner's pN_ready combinationally that cycle, latch we/addr/wdata/port, next state ACCESS (or RESP if error).
REQ-020 pN_ready is 0 outside IDLE and for the losing port; requesters hold valid and payload until ready.
REQ-021 Selection: port 0 wins ties unless run counter equals MAX_P0_RUN and p1_valid, then port 1 wins.
REQ-022 Run counter: +1 on port-0 grant while p1_valid=1; cleared on port-1 grant or on port-0 grant with p1_valid=0; saturates at MAX_P0_RUN.
REQ-023 Error: addr[1:0]!=0 or addr > MEM_BYTES-4 -> skip ACCESS, go RESP with err=1, rdata=0, no memory strobe.
REQ-024 ACCESS: for one cycle drive mem_addr/mem_wdata from latch, mem_read=!we, mem_write=we; capture mem_rdata into response register at end of cycle; next RESP.
REQ-025 RESP: one-cycle pulse pN_rvalid on latched port only; rdata = captured data for reads, 0 for writes; err per REQ-023; next IDLE.
REQ-026 Latency: accept cycle T -> rvalid cycle T+2 (T+1 for error); throughput one transaction per 3 cycles.
REQ-027 mem_read/mem_write SHALL be 0 in IDLE and RESP and never both 1.
REQ-028 mem_addr/mem_wdata hold last latched values outside ACCESS.
REQ-029 pN_valid changes in ACCESS/RESP have no effect on the in-flight transaction.

Reset
REQ-030 rst_n low: state IDLE, run counter 0, latches 0, all outputs 0, immediately (asynchronous).
REQ-031 Reset mid-transaction drops it: no rvalid, memory strobes deassert without waiting for clk.

Structure
REQ-032 Package mem_arb_pkg holds the state enum, port-index constants and MEM_BYTES default.
REQ-033 One sub-module arb_fair_sel: two valids, run counter, MAX_P0_RUN -> grant one-hot plus counter update.
REQ-034 mem_arbiter does not instantiate memory; the top level connects mem_* to it.

Verification
REQ-035 p0 read addr 0x0 alone -> p0_ready at T, mem_read=1 at T+1, p0_rvalid at T+2 with rdata 0x00000004, err 0.
REQ-036 p1 write 0x10 data 0xDEADBEEF, then p0 read 0x10 -> p0_rdata 0xDEADBEEF, p1_rdata 0 on write response.
REQ-037 p0 and p1 valid continuously -> grant order p0,p0,p1,p0,p0,p1.
REQ-038 p0 read addr 0x6 and addr 0x400 -> rvalid one cycle after ready, err 1, rdata 0, mem_read never 1.
REQ-039 rst_n low during ACCESS -> mem_read drops same time step, no rvalid, next request completes normally.
